// File: rtl/sync_ram_clr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_ram_clr_pkg : shared constants, FSM state type, param checks  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package sync_ram_clr_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic bit params_legal(input int data_w, input int addr_w,
                                        input int depth, input int rd_lat,
                                        input int rdw_mode);
        return (data_w >= 1) && (addr_w >= 1) && (addr_w < 31) &&
               (depth >= 1) && (depth <= (1 << addr_w)) &&
               ((rd_lat == 1) || (rd_lat == 2)) &&
               ((rdw_mode == RDW_OLD) || (rdw_mode == RDW_NEW));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_clr_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_ram_clr_if : access bus of the scratch RAM                    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface sync_ram_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              ready;

    modport master (output en, we, addr, wdata, input rdata, rvalid, ready);
    modport slave  (input en, we, addr, wdata, output rdata, rvalid, ready);
endinterface
`default_nettype wire

// File: rtl/sync_ram_clr_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_ram_clr_core : bare array, one synchronous write/read port    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sync_ram_clr_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_ram_clr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_ram_clr : single-port RAM with read pipeline and clear-on-rst |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sync_ram_clr
    import sync_ram_clr_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sync_ram_clr_if.slave bus
);
    if (!params_legal(DATA_W, ADDR_W, DEPTH, RD_LAT, RDW_MODE)) begin : g_bad_params
        $error("sync_ram_clr: illegal parameter combination");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                ready_q, ready_d;
    logic                rd0_q, rd0_d;
    logic                oor0_q, oor0_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic                clearing, clr_last, in_range, acc, user_wr, user_rd;
    logic                core_we, core_re;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata, core_rdata;
    logic                fin_vld;
    logic [DATA_W-1:0]   fin_dat;

    assign clearing = (state_q == ST_CLEAR);
    assign clr_last = (clr_addr_q == ADDR_W'(DEPTH - 1));
    assign in_range = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
    // rst outranks a same-cycle access so nothing lands in the array during reset
    assign acc      = ready_q && bus.en && !rst;
    assign user_wr  = acc && bus.we && in_range;
    assign user_rd  = acc && !bus.we;

    assign core_we    = clearing ? 1'b1       : user_wr;
    assign core_re    = user_rd && in_range;
    assign core_addr  = clearing ? clr_addr_q : bus.addr;
    assign core_wdata = clearing ? '0         : bus.wdata;

    sync_ram_clr_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .re    (core_re),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: state_d = ST_RUN;
        endcase
        ready_d  = (state_d == ST_RUN);
        rd0_d    = user_rd;
        oor0_d   = !in_range;
        rdata_d  = fin_vld ? fin_dat : rdata_q;
        rvalid_d = fin_vld;
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              rd1_q, rd1_d;
        logic [DATA_W-1:0] dat1_q, dat1_d;
        logic [ADDR_W-1:0] raddr0_q, raddr0_d;
        logic              fwd;

        // A write landing while a read of the same word sits in stage 0
        always_comb begin
            raddr0_d = bus.addr;
            rd1_d    = rd0_q;
            fwd      = (RDW_MODE == RDW_NEW) && rd0_q && user_wr &&
                       (bus.addr == raddr0_q);
            if (oor0_q) begin
                dat1_d = '0;
            end else if (fwd) begin
                dat1_d = bus.wdata;
            end else begin
                dat1_d = core_rdata;
            end
        end

        always_ff @(posedge clk) begin
            raddr0_q <= raddr0_d;
            dat1_q   <= dat1_d;
            if (rst) begin
                rd1_q <= 1'b0;
            end else begin
                rd1_q <= rd1_d;
            end
        end

        assign fin_vld = rd1_q;
        assign fin_dat = dat1_q;
    end else begin : g_lat1
        assign fin_vld = rd0_q;
        assign fin_dat = oor0_q ? '0 : core_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            rd0_q      <= 1'b0;
            oor0_q     <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            rd0_q      <= rd0_d;
            oor0_q     <= oor0_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ready  = ready_q;

endmodule
`default_nettype wire
